// File: rtl/frankie_pkg.sv
// Shared definitions for the Frankie multicycle control unit.
// Holds opcode values, ALU codes, FSM state encodings, instruction classes
// and the mux-select encodings driven onto the datapath.
package frankie_pkg;

  // Opcode field values (IR[15:11])
  localparam logic [4:0] OP_LI   = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_SUB  = 5'h03;
  localparam logic [4:0] OP_ADDI = 5'h04;
  localparam logic [4:0] OP_LW   = 5'h05;
  localparam logic [4:0] OP_SW   = 5'h06;
  localparam logic [4:0] OP_PUSH = 5'h07;
  localparam logic [4:0] OP_POP  = 5'h08;
  localparam logic [4:0] OP_BEQ  = 5'h09;
  localparam logic [4:0] OP_BNE  = 5'h0A;
  localparam logic [4:0] OP_JAL  = 5'h0B;
  localparam logic [4:0] OP_RET  = 5'h0C;
  localparam logic [4:0] OP_SWAP = 5'h0D;
  localparam logic [4:0] OP_HALT = 5'h1F;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_PASS = 3'd4;

  // pc_src encodings
  localparam logic [1:0] PCSRC_INC = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;
  localparam logic [1:0] PCSRC_RA  = 2'd3;

  // wb_sel encodings
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_PC  = 2'd3;

  // iord encodings
  localparam logic [1:0] IORD_PC  = 2'd0;
  localparam logic [1:0] IORD_ALU = 2'd1;
  localparam logic [1:0] IORD_SP  = 2'd2;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_ONE = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_LIWB   = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_PUSHSP = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_SWAP   = 4'd12,
    S_HALT   = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  typedef enum logic [3:0] {
    CL_LI, CL_ADD, CL_SUB, CL_ADDI, CL_LW, CL_SW, CL_PUSH, CL_POP,
    CL_BEQ, CL_BNE, CL_JAL, CL_RET, CL_SWAP, CL_HALT, CL_ILL
  } iclass_t;

endpackage

// File: rtl/frankie_control_fsm_op_decode.sv
// Purpose : maps the IR opcode field to an instruction class and a legal flag.
// Latency : purely combinational, zero cycles.
// Backpr. : none; output follows i_opcode.
// Ports   : i_opcode (IR opcode field) -> o_class (instruction class), o_legal.
module frankie_control_fsm_op_decode
  import frankie_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] i_opcode,
  output iclass_t        o_class,
  output logic           o_legal
);

  always_comb begin
    o_class = CL_ILL;
    case (i_opcode)
      OPW'(OP_LI):   o_class = CL_LI;
      OPW'(OP_ADD):  o_class = CL_ADD;
      OPW'(OP_SUB):  o_class = CL_SUB;
      OPW'(OP_ADDI): o_class = CL_ADDI;
      OPW'(OP_LW):   o_class = CL_LW;
      OPW'(OP_SW):   o_class = CL_SW;
      OPW'(OP_PUSH): o_class = CL_PUSH;
      OPW'(OP_POP):  o_class = CL_POP;
      OPW'(OP_BEQ):  o_class = CL_BEQ;
      OPW'(OP_BNE):  o_class = CL_BNE;
      OPW'(OP_JAL):  o_class = CL_JAL;
      OPW'(OP_RET):  o_class = CL_RET;
      OPW'(OP_SWAP): o_class = CL_SWAP;
      OPW'(OP_HALT): o_class = CL_HALT;
      default:       o_class = CL_ILL;
    endcase
    o_legal = (o_class != CL_ILL);
  end

endmodule

// File: rtl/frankie_control_fsm.sv
// Purpose : multicycle control FSM for the Frankie datapath (fetch/decode/exec/mem/wb).
// Latency : 3..5+ cycles per instruction; memory states wait on i_mem_ready.
// Backpr. : o_mem_req/o_mem_we/o_iord held stable until i_mem_ready; watchdog traps on timeout.
// Ports   : i_clock, i_reset (async, active-high), i_opcode (IR field), i_comp (branch flag),
//           i_mem_ready (memory done) ; o_mem_req/o_mem_we/o_iord (memory side),
//           o_ir_write/o_pc_write/o_pc_src/o_alu_*/o_reg_write/o_wb_sel/o_sp_*/o_swap_en
//           (datapath strobes/selects), o_halted/o_trap/o_state (status).
module frankie_control_fsm
  import frankie_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int TOW         = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_comp,
  input  logic           i_mem_ready,
  output logic           o_mem_req,
  output logic           o_mem_we,
  output logic [1:0]     o_iord,
  output logic           o_ir_write,
  output logic           o_pc_write,
  output logic [1:0]     o_pc_src,
  output logic           o_alu_src_a,
  output logic [1:0]     o_alu_src_b,
  output logic [2:0]     o_alu_op,
  output logic           o_reg_write,
  output logic [1:0]     o_wb_sel,
  output logic           o_sp_inc,
  output logic           o_sp_dec,
  output logic           o_swap_en,
  output logic           o_halted,
  output logic           o_trap,
  output logic [3:0]     o_state
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [TOW-1:0] r_wd;
  iclass_t        w_class;
  logic           w_legal;
  logic           w_mem_state;
  logic           w_wd_expire;

  frankie_control_fsm_op_decode #(.OPW(OPW)) u_dec (
    .i_opcode (i_opcode),
    .o_class  (w_class),
    .o_legal  (w_legal)
  );

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // Last permitted waiting cycle without a response: the counter would reach MEM_TIMEOUT.
  assign w_wd_expire = w_mem_state && !i_mem_ready &&
                       (r_wd == TOW'(MEM_TIMEOUT - 1));

  // State and watchdog registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_FETCH;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter restarts on every state change, so each memory state begins at zero.
      if ((w_state_nxt != r_state) || !w_mem_state) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + TOW'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ready)      w_state_nxt = S_DECODE;
        else if (w_wd_expire) w_state_nxt = S_TRAP;
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_state_nxt = S_TRAP;
        end else begin
          case (w_class)
            CL_LI:                   w_state_nxt = S_LIWB;
            CL_ADD, CL_SUB, CL_ADDI: w_state_nxt = S_EXEC;
            CL_LW, CL_SW:            w_state_nxt = S_MEMADR;
            CL_PUSH:                 w_state_nxt = S_PUSHSP;
            CL_POP:                  w_state_nxt = S_MEMRD;
            CL_BEQ, CL_BNE:          w_state_nxt = S_BRANCH;
            CL_JAL, CL_RET:          w_state_nxt = S_JUMP;
            CL_SWAP:                 w_state_nxt = S_SWAP;
            CL_HALT:                 w_state_nxt = S_HALT;
            default:                 w_state_nxt = S_TRAP;
          endcase
        end
      end
      S_EXEC:   w_state_nxt = S_ALUWB;
      S_MEMADR: w_state_nxt = (w_class == CL_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (i_mem_ready)      w_state_nxt = S_MEMWB;
        else if (w_wd_expire) w_state_nxt = S_TRAP;
      end
      S_MEMWR: begin
        if (i_mem_ready)      w_state_nxt = S_FETCH;
        else if (w_wd_expire) w_state_nxt = S_TRAP;
      end
      S_PUSHSP: w_state_nxt = S_MEMWR;
      S_ALUWB, S_LIWB, S_MEMWB, S_BRANCH, S_JUMP, S_SWAP: w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      S_TRAP:   w_state_nxt = S_TRAP;
      default:  w_state_nxt = S_TRAP;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted so a
  // pending memory request drops immediately.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_iord      = IORD_PC;
    o_ir_write  = 1'b0;
    o_pc_write  = 1'b0;
    o_pc_src    = PCSRC_INC;
    o_alu_src_a = 1'b0;
    o_alu_src_b = SRCB_REG;
    o_alu_op    = ALU_ADD;
    o_reg_write = 1'b0;
    o_wb_sel    = WB_ALU;
    o_sp_inc    = 1'b0;
    o_sp_dec    = 1'b0;
    o_swap_en   = 1'b0;
    o_halted    = 1'b0;
    o_trap      = 1'b0;
    o_state     = r_state;
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_iord      = IORD_PC;
          o_alu_src_b = SRCB_ONE;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
          o_pc_src    = PCSRC_INC;
        end
        S_DECODE: begin
          // Precompute PC-relative branch target while decoding.
          o_alu_src_b = SRCB_IMM;
        end
        S_EXEC: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = (w_class == CL_ADDI) ? SRCB_IMM : SRCB_REG;
          o_alu_op    = (w_class == CL_SUB) ? ALU_SUB : ALU_ADD;
        end
        S_ALUWB: begin
          o_reg_write = 1'b1;
          o_wb_sel    = WB_ALU;
        end
        S_LIWB: begin
          o_reg_write = 1'b1;
          o_wb_sel    = WB_IMM;
        end
        S_MEMADR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          o_mem_req = 1'b1;
          o_iord    = (w_class == CL_POP) ? IORD_SP : IORD_ALU;
        end
        S_MEMWB: begin
          o_reg_write = 1'b1;
          o_wb_sel    = WB_MEM;
          o_sp_inc    = (w_class == CL_POP);
        end
        S_MEMWR: begin
          o_mem_req = 1'b1;
          o_mem_we  = 1'b1;
          o_iord    = (w_class == CL_PUSH) ? IORD_SP : IORD_ALU;
        end
        S_PUSHSP: o_sp_dec = 1'b1;
        S_BRANCH: begin
          o_pc_write = i_comp;
          o_pc_src   = PCSRC_BR;
        end
        S_JUMP: begin
          o_pc_write = 1'b1;
          if (w_class == CL_JAL) begin
            o_pc_src    = PCSRC_JMP;
            o_reg_write = 1'b1;
            o_wb_sel    = WB_PC;
          end else begin
            o_pc_src = PCSRC_RA;
          end
        end
        S_SWAP:  o_swap_en = 1'b1;
        S_HALT:  o_halted  = 1'b1;
        S_TRAP:  o_trap    = 1'b1;
        default: o_trap    = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_frankie_control_fsm.sv
// Directed, table-driven bench for the Frankie control FSM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Multi-cycle corner cases (trap, watchdog, halt, reset mid-access) are hand sequences.
module tb_frankie_control_fsm;
  import frankie_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] opc = 5'h0;
  logic       comp = 1'b0;
  logic       rdy = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write, alu_src_a, reg_write;
  logic       sp_inc, sp_dec, swap_en, halted, trap;
  logic [1:0] iord, pc_src, alu_src_b, wb_sel;
  logic [2:0] alu_op;
  logic [3:0] st;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  frankie_control_fsm #(.OPW(5), .MEM_TIMEOUT(15), .TOW(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_opcode(opc), .i_comp(comp), .i_mem_ready(rdy),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord), .o_ir_write(ir_write),
    .o_pc_write(pc_write), .o_pc_src(pc_src), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_reg_write(reg_write),
    .o_wb_sel(wb_sel), .o_sp_inc(sp_inc), .o_sp_dec(sp_dec), .o_swap_en(swap_en),
    .o_halted(halted), .o_trap(trap), .o_state(st)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       we;
    logic [1:0] iord;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wb;
    logic       spi;
    logic       spd;
    logic       sw;
    logic       hlt;
    logic       trp;
  } obs_t;

  typedef struct {
    logic [4:0] op;
    logic       comp;
    logic       rdy;
    obs_t       exp;
    string      name;
  } vec_t;

  vec_t tv[$];

  function automatic obs_t o(logic [3:0] s, logic req, logic we, logic [1:0] io,
                             logic irw, logic pcw, logic [1:0] pcs, logic rw,
                             logic [1:0] wb, logic spi, logic spd, logic sw,
                             logic hlt, logic trp);
    obs_t r;
    r = '{s, req, we, io, irw, pcw, pcs, rw, wb, spi, spd, sw, hlt, trp};
    return r;
  endfunction

  // Fetch completing this cycle, and a state with every strobe low.
  function automatic obs_t f_ok();
    return o(S_FETCH, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic obs_t idle(logic [3:0] s);
    return o(s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Selects are don't-care while their qualifying strobe is low.
  function automatic obs_t msk(obs_t v);
    obs_t r;
    r = v;
    if (!r.pcw) r.pcs = 2'd0;
    if (!r.rw)  r.wb = 2'd0;
    if (!r.req) begin
      r.iord = 2'd0;
      r.we = 1'b0;
    end
    return r;
  endfunction

  function automatic obs_t cur();
    return o(st, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, wb_sel,
             sp_inc, sp_dec, swap_en, halted, trap);
  endfunction

  task automatic chk(input string name, input obs_t exp);
    obs_t a;
    obs_t e;
    a = msk(cur());
    e = msk(exp);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got st=%0d req=%b we=%b iord=%0d irw=%b pcw=%b pcs=%0d rw=%b wb=%0d spi=%b spd=%b sw=%b h=%b t=%b ; want st=%0d req=%b we=%b iord=%0d irw=%b pcw=%b pcs=%0d rw=%b wb=%0d spi=%b spd=%b sw=%b h=%b t=%b",
               name, a.st, a.req, a.we, a.iord, a.irw, a.pcw, a.pcs, a.rw, a.wb, a.spi,
               a.spd, a.sw, a.hlt, a.trp, e.st, e.req, e.we, e.iord, e.irw, e.pcw, e.pcs,
               e.rw, e.wb, e.spi, e.spd, e.sw, e.hlt, e.trp);
    end
  endtask

  // Every output, including ALU selects, must be zero.
  task automatic chk_zero(input string name);
    logic [30:0] all;
    all = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
           reg_write, wb_sel, sp_inc, sp_dec, swap_en, halted, trap, st, 4'h0};
    nchk++;
    if (all !== 31'h0) begin
      nerr++;
      $display("FAIL %s: outputs got %h want 0", name, all);
    end
  endtask

  // One clock cycle: drive inputs after the edge (releasing reset), sample at negedge.
  task automatic cyc(input logic [4:0] op, input logic c, input logic r);
    @(posedge clk);
    #1;
    rst = 1'b0;
    opc = op;
    comp = c;
    rdy = r;
    @(negedge clk);
  endtask

  task automatic rst_pulse(input string name);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy = 1'b0;
    @(negedge clk);
    chk_zero(name);
  endtask

  task automatic add(input logic [4:0] op, input logic c, input logic r, input obs_t e,
                     input string n);
    vec_t v;
    v.op = op; v.comp = c; v.rdy = r; v.exp = e; v.name = n;
    tv.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // LI then ADD, memory always ready
    add(OP_LI,   0, 1, f_ok(),                                          "li_fetch");
    add(OP_LI,   0, 1, idle(S_DECODE),                                  "li_decode");
    add(OP_LI,   0, 1, o(S_LIWB, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0),  "li_wb");
    add(OP_ADD,  0, 1, f_ok(),                                          "add_fetch");
    add(OP_ADD,  0, 1, idle(S_DECODE),                                  "add_decode");
    add(OP_ADD,  0, 1, idle(S_EXEC),                                    "add_exec");
    add(OP_ADD,  0, 1, o(S_ALUWB, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "add_wb");
    // LW with two wait cycles in MEMRD; ready during MEMADR is ignored
    add(OP_LW,   0, 1, f_ok(),                                          "lw_fetch");
    add(OP_LW,   0, 1, idle(S_DECODE),                                  "lw_decode");
    add(OP_LW,   0, 1, idle(S_MEMADR),                                  "lw_memadr");
    add(OP_LW,   0, 0, o(S_MEMRD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_rd_wait1");
    add(OP_LW,   0, 0, o(S_MEMRD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_rd_wait2");
    add(OP_LW,   0, 1, o(S_MEMRD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_rd_done");
    add(OP_LW,   0, 1, o(S_MEMWB, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "lw_wb");
    // PUSH then POP
    add(OP_PUSH, 0, 1, f_ok(),                                          "push_fetch");
    add(OP_PUSH, 0, 1, idle(S_DECODE),                                  "push_decode");
    add(OP_PUSH, 0, 1, o(S_PUSHSP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "push_spdec");
    add(OP_PUSH, 0, 1, o(S_MEMWR, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "push_memwr");
    add(OP_POP,  0, 1, f_ok(),                                          "pop_fetch");
    add(OP_POP,  0, 1, idle(S_DECODE),                                  "pop_decode");
    add(OP_POP,  0, 1, o(S_MEMRD, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "pop_memrd");
    add(OP_POP,  0, 1, o(S_MEMWB, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), "pop_wb");
    // Branches taken and not taken
    add(OP_BEQ,  0, 1, f_ok(),                                          "beq1_fetch");
    add(OP_BEQ,  0, 1, idle(S_DECODE),                                  "beq1_decode");
    add(OP_BEQ,  1, 1, o(S_BRANCH, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "beq_taken");
    add(OP_BEQ,  0, 1, f_ok(),                                          "beq2_fetch");
    add(OP_BEQ,  0, 1, idle(S_DECODE),                                  "beq2_decode");
    add(OP_BEQ,  0, 1, idle(S_BRANCH),                                  "beq_not_taken");
    add(OP_BNE,  0, 1, f_ok(),                                          "bne_fetch");
    add(OP_BNE,  0, 1, idle(S_DECODE),                                  "bne_decode");
    add(OP_BNE,  1, 1, o(S_BRANCH, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "bne_taken");
    // JAL, RET, SWAP, SW
    add(OP_JAL,  0, 1, f_ok(),                                          "jal_fetch");
    add(OP_JAL,  0, 1, idle(S_DECODE),                                  "jal_decode");
    add(OP_JAL,  0, 1, o(S_JUMP, 0, 0, 0, 0, 1, 2, 1, 3, 0, 0, 0, 0, 0),  "jal_jump");
    add(OP_RET,  0, 1, f_ok(),                                          "ret_fetch");
    add(OP_RET,  0, 1, idle(S_DECODE),                                  "ret_decode");
    add(OP_RET,  0, 1, o(S_JUMP, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0),  "ret_jump");
    add(OP_SWAP, 0, 1, f_ok(),                                          "swap_fetch");
    add(OP_SWAP, 0, 1, idle(S_DECODE),                                  "swap_decode");
    add(OP_SWAP, 0, 1, o(S_SWAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),  "swap_exec");
    add(OP_SW,   0, 1, f_ok(),                                          "sw_fetch");
    add(OP_SW,   0, 1, idle(S_DECODE),                                  "sw_decode");
    add(OP_SW,   0, 1, idle(S_MEMADR),                                  "sw_memadr");
    add(OP_SW,   0, 1, o(S_MEMWR, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_memwr");
    // Fetch waiting: request up, no strobes
    add(OP_LI,   0, 0, o(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");

    // Reset state
    @(negedge clk);
    chk_zero("reset_init");

    foreach (tv[i]) begin
      cyc(tv[i].op, tv[i].comp, tv[i].rdy);
      chk(tv[i].name, tv[i].exp);
    end

    // SUB: ALU controls during EXEC
    cyc(OP_SUB, 0, 1);
    chk("sub_fetch", f_ok());
    cyc(OP_SUB, 0, 1);
    cyc(OP_SUB, 0, 1);
    nchk++;
    if (st !== 4'(S_EXEC) || alu_op !== ALU_SUB || alu_src_a !== 1'b1 || alu_src_b !== SRCB_REG) begin
      nerr++;
      $display("FAIL sub_exec_alu: got st=%0d op=%0d a=%b b=%0d want st=%0d op=%0d a=1 b=0",
               st, alu_op, alu_src_a, alu_src_b, S_EXEC, ALU_SUB);
    end
    cyc(OP_SUB, 0, 1);
    chk("sub_wb", o(S_ALUWB, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Illegal opcode traps right after decode and holds
    cyc(5'h1E, 0, 1);
    chk("ill_fetch", f_ok());
    cyc(5'h1E, 0, 1);
    chk("ill_decode", idle(S_DECODE));
    for (int i = 0; i < 3; i++) begin
      cyc(5'h1E, 0, 1);
      chk("ill_trap_hold", o(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    rst_pulse("reset_after_trap");

    // Fetch watchdog: 15 cycles without ready -> TRAP
    for (int i = 1; i <= 15; i++) begin
      cyc(OP_LI, 0, 0);
      chk("wd_fetch_wait", o(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    cyc(OP_LI, 0, 1);
    chk("wd_trap", o(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_pulse("reset_after_wd");

    // HALT holds until reset
    cyc(OP_HALT, 0, 1);
    chk("halt_fetch", f_ok());
    cyc(OP_HALT, 0, 1);
    chk("halt_decode", idle(S_DECODE));
    for (int i = 0; i < 2; i++) begin
      cyc(OP_HALT, 0, 1);
      chk("halt_hold", o(S_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    rst_pulse("reset_after_halt");

    // Reset asserted while MEMWR is waiting
    cyc(OP_SW, 0, 1);
    cyc(OP_SW, 0, 1);
    cyc(OP_SW, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(OP_SW, 0, 0);
      chk("sw_wr_wait", o(S_MEMWR, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    #2;
    rst = 1'b1;
    #1;
    chk_zero("reset_mid_memwr");

    // After release the watchdog starts from zero: ready on the 15th cycle still wins
    for (int i = 1; i <= 14; i++) begin
      cyc(OP_LI, 0, 0);
    end
    chk("post_rst_wait14", o(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(OP_LI, 0, 1);
    chk("wd_ready_on_15th", f_ok());
    cyc(OP_LI, 0, 1);
    chk("wd_boundary_decode", idle(S_DECODE));
    cyc(OP_LI, 0, 1);
    chk("wd_boundary_liwb", o(S_LIWB, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
